usb_fs_bit_tx: RTL and testbench

Full-speed (12 Mb/s) USB bit-level transmitter that drives the D+/D- line from a byte stream. It prepends SYNC, shifts bytes LSB-first, inserts stuff bits, NRZI-encodes the result, and appends EOP (SE0, SE0, J). It is the transmit counterpart of the bit-level receiver and shares the 60 MHz clock, which gives 5 clocks per bit, with the receiver. It sits between the packet layer and the line transceiver; `oe` arbitrates line ownership.

---
 rtl/usb_fs_bit_tx.sv | 334 +++++++++++++++++++++++++++++++++
 tb/tb_usb_fs_bit_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_fs_bit_tx.sv
// ---------------------------------------------------------------------------
// usb_fs_bit_tx
// Full-speed USB bit-level transmitter. The block takes a byte stream from the
// packet layer and drives D+/D-. It sends SYNC first, then the bytes LSB-first
// with bit stuffing, NRZI-encodes every bit, and finishes with EOP (SE0, SE0, J).
// Every line bit is held for CLKS_PER_BIT clocks of the shared 60 MHz clock.
//
// Optional feature macro: USB_TX_PRE_J_EN
//   When it is defined, one driven J bit comes before SYNC.
//   When it is undefined, SYNC starts on the clock after the first accept.
//
// Parameters
//   CLKS_PER_BIT  clocks per line bit (5 at 60 MHz)
//   STUFF_LIMIT   run length of 1s that forces a stuffed 0
//
// Ports
//   clk       60 MHz clock
//   rst       synchronous, active-high reset
//   tx_valid  byte available on tx_data
//   tx_data   byte to send, LSB first
//   tx_last   marks the accepted byte as the final byte of the packet
//   tx_ready  holding register can take a byte (accept = tx_valid && tx_ready)
//   tx_dp     registered D+ drive value
//   tx_dn     registered D- drive value
//   oe        1 while the transmitter owns the line
//   tx_busy   packet in progress, from first accept to the tx_done cycle
//   tx_done   one-cycle pulse when the packet is complete
//   tx_error  one-cycle pulse when the data underruns
// ---------------------------------------------------------------------------
module usb_fs_bit_tx #(
  parameter int CLKS_PER_BIT = 5,
  parameter int STUFF_LIMIT  = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_dp,
  output logic       tx_dn,
  output logic       oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int ONES_W = $clog2(STUFF_LIMIT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ONES_W-1:0] ONES_MAX = ONES_W'(STUFF_LIMIT);

  typedef enum logic [3:0] {
    S_IDLE,
    S_PREJ,
    S_SYNC,
    S_DATA,
    S_STUFF,
    S_EOP1,
    S_EOP2,
    S_EOPJ,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  // Control state
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [2:0]        bit_idx, bit_idx_nxt;
  logic [ONES_W-1:0] ones_cnt, ones_nxt;
  logic              lvl, lvl_nxt;          // NRZI level, 1 = J
  logic              hold_full, hold_full_nxt;
  logic              lock, lock_nxt;        // last byte taken, refuse more
  logic              dp_nxt, dn_nxt, oe_nxt;
  logic              tx_ready_nxt, tx_busy_nxt, tx_done_nxt, tx_error_nxt;

  // Datapath state (not reset)
  logic [7:0]        hold_data, hold_data_nxt;
  logic              hold_last, hold_last_nxt;
  logic [7:0]        cur_byte, cur_byte_nxt;
  logic              cur_last, cur_last_nxt;

  // Per-cycle decisions
  logic              accept;
  logic              bit_end;
  logic              byte_end;
  logic              emit_data;
  logic              emit_val;
  logic              drive_lvl;
  logic              drive_se0;

  assign accept  = tx_valid && tx_ready;
  assign bit_end = (bit_cnt == CNT_LAST);

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_end ? '0 : bit_cnt + CNT_W'(1);
    bit_idx_nxt   = bit_idx;
    ones_nxt      = ones_cnt;
    lvl_nxt       = lvl;
    hold_full_nxt = hold_full;
    lock_nxt      = lock;
    dp_nxt        = tx_dp;
    dn_nxt        = tx_dn;
    oe_nxt        = oe;
    tx_busy_nxt   = tx_busy;
    tx_done_nxt   = 1'b0;
    tx_error_nxt  = 1'b0;
    hold_data_nxt = hold_data;
    hold_last_nxt = hold_last;
    cur_byte_nxt  = cur_byte;
    cur_last_nxt  = cur_last;
    byte_end      = 1'b0;
    emit_data     = 1'b0;
    emit_val      = 1'b0;
    drive_lvl     = 1'b0;
    drive_se0     = 1'b0;

    if (accept) begin
      hold_data_nxt = tx_data;
      hold_last_nxt = tx_last;
      hold_full_nxt = 1'b1;
      if (tx_last) begin
        lock_nxt = 1'b1;
      end
    end

    case (state)
      S_IDLE: begin
        bit_cnt_nxt = '0;
        if (accept) begin
          bit_idx_nxt = '0;
          ones_nxt    = '0;
          oe_nxt      = 1'b1;
          tx_busy_nxt = 1'b1;
`ifdef USB_TX_PRE_J_EN
          state_nxt   = S_PREJ;
          lvl_nxt     = 1'b1;
          drive_lvl   = 1'b1;
`else
          state_nxt   = S_SYNC;
          emit_data   = 1'b1;
          emit_val    = 1'b0;
`endif
        end
      end

      S_PREJ: begin
        if (bit_end) begin
          state_nxt   = S_SYNC;
          bit_idx_nxt = '0;
          emit_data   = 1'b1;
          emit_val    = 1'b0;
        end
      end

      // SYNC is seven 0s followed by a 1; the first data bit comes from the
      // holding register, which is always full here because the accept started
      // the packet.
      S_SYNC: begin
        if (bit_end) begin
          if (bit_idx != 3'd7) begin
            bit_idx_nxt = bit_idx + 3'd1;
            emit_data   = 1'b1;
            emit_val    = (bit_idx == 3'd6);
          end else begin
            state_nxt     = S_DATA;
            cur_byte_nxt  = hold_data;
            cur_last_nxt  = hold_last;
            hold_full_nxt = 1'b0;
            bit_idx_nxt   = '0;
            emit_data     = 1'b1;
            emit_val      = hold_data[0];
          end
        end
      end

      // The stuff check comes before the shift, so a stuffed 0 can follow the
      // final bit of a byte before the byte boundary is handled.
      S_DATA: begin
        if (bit_end) begin
          if (ones_cnt == ONES_MAX) begin
            state_nxt = S_STUFF;
            lvl_nxt   = ~lvl;
            ones_nxt  = '0;
            drive_lvl = 1'b1;
          end else if (bit_idx != 3'd7) begin
            bit_idx_nxt = bit_idx + 3'd1;
            emit_data   = 1'b1;
            emit_val    = cur_byte[bit_idx + 3'd1];
          end else begin
            byte_end = 1'b1;
          end
        end
      end

      S_STUFF: begin
        if (bit_end) begin
          if (bit_idx != 3'd7) begin
            state_nxt   = S_DATA;
            bit_idx_nxt = bit_idx + 3'd1;
            emit_data   = 1'b1;
            emit_val    = cur_byte[bit_idx + 3'd1];
          end else begin
            byte_end = 1'b1;
          end
        end
      end

      S_EOP1: begin
        if (bit_end) begin
          state_nxt = S_EOP2;
          drive_se0 = 1'b1;
        end
      end

      S_EOP2: begin
        if (bit_end) begin
          state_nxt = S_EOPJ;
          lvl_nxt   = 1'b1;
          drive_lvl = 1'b1;
        end
      end

      S_EOPJ: begin
        if (bit_end) begin
          state_nxt   = S_DONE;
          bit_cnt_nxt = '0;
          oe_nxt      = 1'b0;
          tx_busy_nxt = 1'b0;
          tx_done_nxt = 1'b1;
        end
      end

      S_DONE: begin
        state_nxt   = S_IDLE;
        bit_cnt_nxt = '0;
        lock_nxt    = 1'b0;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // At a byte boundary the packet ends, the next byte is loaded, or the
    // data has underrun. A byte that arrives on the underrun edge itself is
    // dropped, because no further data follows an underrun.
    if (byte_end) begin
      if (cur_last) begin
        state_nxt = S_EOP1;
        drive_se0 = 1'b1;
      end else if (hold_full) begin
        state_nxt     = S_DATA;
        cur_byte_nxt  = hold_data;
        cur_last_nxt  = hold_last;
        hold_full_nxt = 1'b0;
        bit_idx_nxt   = '0;
        emit_data     = 1'b1;
        emit_val      = hold_data[0];
      end else begin
        state_nxt     = S_EOP1;
        tx_error_nxt  = 1'b1;
        hold_full_nxt = 1'b0;
        drive_se0     = 1'b1;
      end
    end

    // NRZI: a 0 toggles the line and a 1 holds it.
    if (emit_data) begin
      if (!emit_val) begin
        lvl_nxt = ~lvl;
      end
      ones_nxt  = emit_val ? ones_cnt + ONES_W'(1) : '0;
      drive_lvl = 1'b1;
    end

    if (drive_lvl) begin
      dp_nxt = lvl_nxt;
      dn_nxt = ~lvl_nxt;
    end
    if (drive_se0) begin
      dp_nxt = 1'b0;
      dn_nxt = 1'b0;
    end

    tx_ready_nxt = !hold_full_nxt && !lock_nxt &&
                   (state_nxt inside {S_IDLE, S_PREJ, S_SYNC, S_DATA, S_STUFF});
  end

  // State and control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      ones_cnt  <= '0;
      lvl       <= 1'b1;
      hold_full <= 1'b0;
      lock      <= 1'b0;
      tx_dp     <= 1'b1;
      tx_dn     <= 1'b0;
      oe        <= 1'b0;
      tx_ready  <= 1'b0;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
      tx_error  <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      ones_cnt  <= ones_nxt;
      lvl       <= lvl_nxt;
      hold_full <= hold_full_nxt;
      lock      <= lock_nxt;
      tx_dp     <= dp_nxt;
      tx_dn     <= dn_nxt;
      oe        <= oe_nxt;
      tx_ready  <= tx_ready_nxt;
      tx_busy   <= tx_busy_nxt;
      tx_done   <= tx_done_nxt;
      tx_error  <= tx_error_nxt;
    end
  end

  // Byte registers
  always_ff @(posedge clk) begin
    hold_data <= hold_data_nxt;
    hold_last <= hold_last_nxt;
    cur_byte  <= cur_byte_nxt;
    cur_last  <= cur_last_nxt;
  end

endmodule

// File: tb/tb_usb_fs_bit_tx.sv
// ---------------------------------------------------------------------------
// tb_usb_fs_bit_tx
// Testbench for usb_fs_bit_tx. A reference model expands each packet into the
// expected sequence of line symbols: SYNC and the data bits, stuffing after
// six 1s, NRZI starting from J, then SE0 SE0 J. It then checks every clock of
// the captured line against that sequence.
// ---------------------------------------------------------------------------
module tb_usb_fs_bit_tx;

  localparam int STUFF_LIMIT = 6;
  localparam logic [1:0] SYM_J   = 2'b10;
  localparam logic [1:0] SYM_K   = 2'b01;
  localparam logic [1:0] SYM_SE0 = 2'b00;
`ifdef USB_TX_PRE_J_EN
  localparam int PRE_BITS = 1;
`else
  localparam int PRE_BITS = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_ready;
  logic       tx_dp;
  logic       tx_dn;
  logic       oe;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  usb_fs_bit_tx #(.CLKS_PER_BIT(5), .STUFF_LIMIT(STUFF_LIMIT)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_last  (tx_last),
    .tx_ready (tx_ready),
    .tx_dp    (tx_dp),
    .tx_dn    (tx_dn),
    .oe       (oe),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .tx_error (tx_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;

  logic [7:0] pkt[$];
  logic [1:0] expq[$];
  logic [1:0] cap[$];

  bit   cap_fin;
  int   n_errp;
  int   err_at;
  int   first_oe;
  int   acc_cyc;
  bit   rdy_after_last;
  bit   drv_to;
  bit   busy_first;
  logic done_oe;
  logic done_busy;
  logic [1:0] done_line;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: bit list -> stuffed NRZI symbol list, one entry per bit time.
  task automatic build_exp();
    bit   bits[$];
    logic lvl;
    int   ones;
    expq.delete();
    for (int i = 0; i < 7; i++) bits.push_back(1'b0);
    bits.push_back(1'b1);
    foreach (pkt[i]) for (int k = 0; k < 8; k++) bits.push_back(pkt[i][k]);
    lvl  = 1'b1;
    ones = 0;
    for (int i = 0; i < PRE_BITS; i++) expq.push_back(SYM_J);
    foreach (bits[i]) begin
      if (!bits[i]) lvl = ~lvl;
      expq.push_back(lvl ? SYM_J : SYM_K);
      ones = bits[i] ? ones + 1 : 0;
      if (ones == STUFF_LIMIT) begin
        lvl = ~lvl;
        expq.push_back(lvl ? SYM_J : SYM_K);
        ones = 0;
      end
    end
    expq.push_back(SYM_SE0);
    expq.push_back(SYM_SE0);
    expq.push_back(SYM_J);
  endtask

  // Sends pkt and captures the line until tx_done, then checks everything.
  // The task is entered just after a negedge with the DUT idle.
  task automatic run_packet(input bit with_last, input bit junk, input int gap1);
    cap.delete();
    cap_fin = 1'b0; n_errp = 0; err_at = -1; first_oe = -1; acc_cyc = -1;
    rdy_after_last = 1'b1; drv_to = 1'b0; busy_first = 1'b0;
    done_oe = 1'bx; done_busy = 1'bx; done_line = 2'bxx;
    fork
      begin : drv_b
        int w;
        for (int i = 0; i < pkt.size(); i++) begin
          tx_valid = 1'b1;
          tx_data  = pkt[i];
          tx_last  = with_last && (i == pkt.size() - 1);
          w = 0;
          while (!tx_ready && w < 600) begin @(negedge clk); w++; end
          if (w >= 600) drv_to = 1'b1;
          if (i == 0) acc_cyc = cyc;
          @(negedge clk);
          if (tx_last) rdy_after_last = tx_ready;
          tx_valid = 1'b0;
          tx_last  = 1'b0;
          tx_data  = 8'($urandom);
          if (i + 1 < pkt.size())
            repeat ((i == 0) ? $urandom_range(0, gap1) : $urandom_range(0, 20)) @(negedge clk);
        end
        if (junk && with_last) begin
          tx_valid = 1'b1;
          w = 0;
          while (!tx_done && w < 3000) begin
            tx_data = 8'($urandom);
            tx_last = 1'($urandom);
            @(negedge clk);
            w++;
          end
          tx_valid = 1'b0;
          tx_last  = 1'b0;
        end
      end
      begin : cap_b
        int t;
        t = 0;
        while (!cap_fin && t < 3000) begin
          @(negedge clk);
          t++;
          if (tx_error) begin n_errp++; err_at = cap.size(); end
          if (oe) begin
            if (first_oe < 0) begin first_oe = cyc; busy_first = tx_busy; end
            cap.push_back({tx_dp, tx_dn});
          end
          if (tx_done) begin
            cap_fin   = 1'b1;
            done_oe   = oe;
            done_busy = tx_busy;
            done_line = {tx_dp, tx_dn};
          end
        end
      end
    join

    build_exp();
    check("done_seen", cap_fin, 1);
    check("driver_accept", drv_to, 0);
    check("oe_len", cap.size(), expq.size() * 5);
    for (int i = 0; i < cap.size(); i++)
      if (i / 5 < expq.size()) check($sformatf("line[%0d]", i), cap[i], expq[i / 5]);
    check("first_bit_latency", first_oe, acc_cyc + 1);
    check("busy_in_packet", busy_first, 1);
    check("error_pulses", n_errp, with_last ? 0 : 1);
    if (!with_last) check("error_pos", err_at, (expq.size() - 3) * 5);
    if (with_last) check("ready_after_last", rdy_after_last, 0);
    check("done_oe", done_oe, 0);
    check("done_busy", done_busy, 0);
    check("done_line", done_line, SYM_J);
    @(negedge clk);
    check("done_single", tx_done, 0);
    check("ready_after_done", tx_ready, 1);
  endtask

  initial begin
    int w;
    int n;
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dp", tx_dp, 1);
    check("rst_dn", tx_dn, 0);
    check("rst_oe", oe, 0);
    check("rst_ready", tx_ready, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_error", tx_error, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", tx_ready, 1);

    // Single 0x00: alternating data, no stuffing.
    pkt.delete(); pkt.push_back(8'h00);
    run_packet(1'b1, 1'b0, 0);
    check("oe_len_00", cap.size(), 95 + 5 * PRE_BITS);

    // Single 0xFF: a stuffed J after the fifth data 1.
    pkt.delete(); pkt.push_back(8'hFF);
    run_packet(1'b1, 1'b1, 0);
    check("oe_len_ff", cap.size(), 100 + 5 * PRE_BITS);
    check("ff_5th_one", cap[(12 + PRE_BITS) * 5], SYM_K);
    check("ff_stuff", cap[(13 + PRE_BITS) * 5], SYM_J);

    // Two bytes; the second is accepted while the first is on the line.
    pkt.delete(); pkt.push_back(8'hA5); pkt.push_back(8'h3C);
    run_packet(1'b1, 1'b0, 70);

    // Underrun after one unflagged byte.
    pkt.delete(); pkt.push_back(8'h12);
    run_packet(1'b0, 1'b0, 0);

    // Reset during the third data bit.
    tx_valid = 1'b1; tx_data = 8'h00; tx_last = 1'b1;
    w = 0;
    while (!tx_ready && w < 100) begin @(negedge clk); w++; end
    @(negedge clk);
    tx_valid = 1'b0; tx_last = 1'b0;
    repeat (52 + 5 * PRE_BITS) @(negedge clk);
    check("pre_rst_oe", oe, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_oe", oe, 0);
    check("midrst_line", {tx_dp, tx_dn}, SYM_J);
    check("midrst_busy", tx_busy, 0);
    check("midrst_ready", tx_ready, 0);
    check("midrst_done", tx_done, 0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready_release", tx_ready, 1);

    // Random packets, biased toward 0xFF so that stuffing crosses bytes.
    for (int p = 0; p < 8; p++) begin
      pkt.delete();
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++)
        pkt.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
      run_packet($urandom_range(0, 4) != 0, 1'($urandom), 70);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
